// File: rtl/datapath_arbiter.sv
// Two-requester arbiter in front of a shared, pipelined arithmetic datapath.
// Requests are granted combinationally. The winner's operands are registered
// onto dp_a/dp_b/dp_opcode. A tag pipeline of depth LAT+1 tracks which
// requester owns the result that emerges from the datapath.
// Build option: define DP_ARB_FIXED_PRIO_EN to make requester 0 always win a
// contention. By default the two requesters alternate (round-robin).
module datapath_arbiter #(
    parameter int unsigned N   = 16,
    parameter int unsigned LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic [N-1:0] dp_a,
    output logic [N-1:0] dp_b,
    output logic [2:0]   dp_opcode,
    input  logic [N-1:0] dp_y,
    input  logic         dp_co,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    output logic [N-1:0] rsp_y,
    output logic         rsp_co,
    output logic [2:0]   inflight
);

    // Id of the requester granted most recently; resets to 1 so requester 0 wins first.
    logic         last_grant;
    logic         grant0;
    logic         grant1;
    logic         xfer;
    logic         win_id;
    logic [N-1:0] win_a;
    logic [N-1:0] win_b;
    logic [2:0]   win_op;

    // Tag pipeline: stage 0 receives the issue, stage LAT lines up with dp_y/dp_co.
    logic [LAT:0] tag_v;
    logic [LAT:0] tag_id;
    logic         rsp_fire;
    logic [2:0]   inflight_d;

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (req0_valid && req1_valid) begin
`ifdef DP_ARB_FIXED_PRIO_EN
                grant0 = 1'b1;
`else
                if (last_grant) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
`endif
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 | grant1;
    assign win_id     = grant1;

    // Select the winning requester's operation.
    always_comb begin
        win_a  = req0_a;
        win_b  = req0_b;
        win_op = req0_op;
        if (grant1) begin
            win_a  = req1_a;
            win_b  = req1_b;
            win_op = req1_op;
        end
    end

    // Operand registers and grant history load only on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_a       <= '0;
            dp_b       <= '0;
            dp_opcode  <= 3'd0;
            last_grant <= 1'b1;
        end else if (xfer) begin
            dp_a       <= win_a;
            dp_b       <= win_b;
            dp_opcode  <= win_op;
            last_grant <= win_id;
        end
    end

    // Shift the tag pipeline every cycle; idle cycles insert an invalid tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= xfer;
            tag_id[0] <= win_id;
            for (int i = 1; i <= int'(LAT); i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign rsp_fire = tag_v[LAT];

    // Capture the datapath result when a valid tag leaves the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_y      <= '0;
            rsp_co     <= 1'b0;
        end else begin
            rsp0_valid <= rsp_fire & ~tag_id[LAT];
            rsp1_valid <= rsp_fire & tag_id[LAT];
            if (rsp_fire) begin
                rsp_y  <= dp_y;
                rsp_co <= dp_co;
            end
        end
    end

    // Occupancy next state; the count never exceeds LAT+1, so it cannot wrap.
    always_comb begin
        inflight_d = inflight;
        if (xfer && !rsp_fire) begin
            inflight_d = inflight + 3'd1;
        end else if (!xfer && rsp_fire) begin
            inflight_d = inflight - 3'd1;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 3'd0;
        end else begin
            inflight <= inflight_d;
        end
    end

endmodule

// File: doc/datapath_arbiter.md
DATAPATH_ARBITER -- requirements
Module: datapath_arbiter

Interface
REQ-001 Parameter N, default 16: operand and result width in bits, two's-complement signed.
REQ-002 Parameter LAT, default 2: register stages inside the shared datapath from its A/B/opcode inputs to its Y/co outputs; legal range 0..4.
REQ-003 Clock and reset are clk and rst_n; there is one clock, and reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock shared with the datapath.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req0_valid, req1_valid  in  1  requester operation offered.
REQ-007 req0_ready, req1_ready  out  1  requester operation accepted this cycle.
REQ-008 req0_a, req0_b, req1_a, req1_b  in  N  signed operands per requester.
REQ-009 req0_op, req1_op  in  3  opcode per requester; all 8 codes are passed through unchanged.
REQ-010 dp_a, dp_b  out  N  registered operands driven to the datapath.
REQ-011 dp_opcode  out  3  registered opcode driven to the datapath.
REQ-012 dp_y  in  N  datapath result.
REQ-013 dp_co  in  1  datapath carry-out.
REQ-014 rsp0_valid, rsp1_valid  out  1  one-cycle result strobe per requester.
REQ-015 rsp_y  out  N  registered result, qualified by rsp0_valid or rsp1_valid.
REQ-016 rsp_co  out  1  registered carry-out, qualified the same way.
REQ-017 inflight  out  3  count of issued operations whose response is not yet delivered.

Function
REQ-018 A transfer occurs on a rising edge when reqX_valid and reqX_ready are both high; at most one transfer occurs per cycle.
REQ-019 Grant is combinational from the valid inputs and the last_grant register. One valid input wins. With both valid, the requester that was not last granted wins. No valid input means no ready is asserted.
REQ-020 reqX_ready is never asserted unless reqX_valid is high; a waiting requester holds valid and its operands stable until ready.
REQ-021 On transfer, dp_a, dp_b and dp_opcode load the winner's operands, and last_grant loads the winner's id. With no transfer, dp_* and last_grant hold.
REQ-022 A tag shift register of depth LAT+1 holds {valid, id}; the transfer pushes {1, winner id}, and an idle cycle pushes {0, x}.
REQ-023 When the tag leaving the final stage is valid, rsp_y and rsp_co capture dp_y and dp_co on that edge, and the matching rspX_valid is high for exactly one cycle.
REQ-024 Latency: a transfer sampled at edge k gives rspX_valid high in the cycle after edge k+LAT+1; back-to-back issues give back-to-back responses, one per cycle, in issue order.
REQ-025 With LAT=0, the datapath is combinational and the response follows edge k+1.
REQ-026 Responses have no backpressure; the requester is always able to accept them.
REQ-027 inflight increments on a transfer and decrements on a response strobe. A transfer and a response on the same edge leave it unchanged. Its maximum is LAT+1, so it never wraps.
REQ-028 rsp_y and rsp_co hold their last value when no response is strobed.

Reset
REQ-029 While rst_n is low, all of the following hold regardless of clk: dp_a=0, dp_b=0, dp_opcode=0, rsp_y=0, rsp_co=0, rsp0_valid=0, rsp1_valid=0, inflight=0, every tag stage invalid, and last_grant=1 (so requester 0 wins the first contention).
REQ-030 While rst_n is low, req0_ready and req1_ready are forced to 0.
REQ-031 Reset asserted mid-operation discards all in-flight operations, and no response is ever strobed for them.
REQ-032 The first transfer after release occurs on the first rising edge with rst_n high and a valid request.

Configuration
REQ-033 Macro DP_ARB_FIXED_PRIO_EN is defined: requester 0 always wins when both are valid, and last_grant is still recorded but does not affect grant.
REQ-034 Macro DP_ARB_FIXED_PRIO_EN is undefined: round-robin per REQ-019; all other behaviour is identical.

Verification
REQ-035 LAT=2, a single req0 with A=5, B=3, op=000 (sum) at edge 1 -> rsp0_valid at the cycle after edge 4, rsp_y=8, rsp_co=0, and inflight returns to 0.
REQ-036 Both valid for 4 cycles, round-robin build -> grants alternate 0,1,0,1, and the responses arrive in the same order on consecutive cycles.
REQ-037 Both valid for 4 cycles, DP_ARB_FIXED_PRIO_EN build -> req0 granted every cycle, and req1_ready stays 0.
REQ-038 LAT=2, continuous issue from req1 -> inflight saturates at 3 with no overflow.
REQ-039 rst_n pulsed low with 2 operations in flight -> all outputs read as reset values asynchronously, and no rsp strobe follows release.
REQ-040 A=32767, B=1, sum on req1 -> rsp1_valid, with rsp_y and rsp_co equal to the datapath's dp_y and dp_co, passed unmodified.
